// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - byte-addressed load/store front-end for a single-port word RAM
module memory_access_unit #(
  parameter int ADDRESS_SIZE = 10,
  parameter int WORD_SIZE    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDRESS_SIZE+1:0] req_address,
  input  logic [WORD_SIZE-1:0]    req_write_data,
  output logic                    resp_valid,
  output logic                    resp_error,
  output logic [WORD_SIZE-1:0]    resp_data,
  output logic                    mem_read_enable,
  output logic                    mem_write_enable,
  output logic [ADDRESS_SIZE-1:0] mem_read_address,
  output logic [ADDRESS_SIZE-1:0] mem_write_address,
  output logic [WORD_SIZE-1:0]    mem_write_data,
  input  logic [WORD_SIZE-1:0]    mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    write_q;
  logic [1:0]              size_q;
  logic                    unsigned_q;
  logic [1:0]              offset_q;
  logic [ADDRESS_SIZE-1:0] waddr_q;
  logic [WORD_SIZE-1:0]    wdata_q;
  logic                    error_q;
  logic [WORD_SIZE-1:0]    resp_data_q;

  logic                    misaligned;
  logic                    accept;
  logic [7:0]              load_byte;
  logic [15:0]             load_half;
  logic [WORD_SIZE-1:0]    load_ext;
  logic [WORD_SIZE-1:0]    merged;

  // Size 11 is never legal; half and word need natural alignment.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_address[0];
      2'b10:   misaligned = (req_address[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign accept = req_valid && (state_q == S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: aligned requests visit ACCESS, misaligned go straight to RESPOND.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = misaligned ? S_RESPOND : S_ACCESS;
        end
      end
      S_ACCESS:  state_d = S_RESPOND;
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs; RAM enables are gated by reset so an in-flight write is dropped.
  always_comb begin
    req_ready        = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    resp_valid       = 1'b0;
    resp_error       = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready       = 1'b1;
        mem_read_enable = req_valid && !misaligned && !reset;
      end
      S_ACCESS: begin
        mem_write_enable = write_q && !reset;
      end
      S_RESPOND: begin
        resp_valid = !reset;
        resp_error = error_q && !reset;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // Request capture on accept and response data update.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      offset_q    <= 2'b00;
      waddr_q     <= '0;
      wdata_q     <= '0;
      error_q     <= 1'b0;
      resp_data_q <= '0;
    end else begin
      if (accept) begin
        write_q    <= req_write;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        offset_q   <= req_address[1:0];
        waddr_q    <= req_address[ADDRESS_SIZE+1:2];
        wdata_q    <= req_write_data;
        error_q    <= misaligned;
        if (misaligned) begin
          resp_data_q <= '0;
        end
      end
      if (state_q == S_ACCESS) begin
        resp_data_q <= write_q ? '0 : load_ext;
      end
    end
  end

  // Lane select and sign/zero extension of the word returned by the RAM.
  always_comb begin
    load_byte = mem_read_data[{offset_q, 3'b000} +: 8];
    load_half = mem_read_data[{offset_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {{(WORD_SIZE-8){1'b0}}, load_byte}
                                     : {{(WORD_SIZE-8){load_byte[7]}}, load_byte};
      2'b01:   load_ext = unsigned_q ? {{(WORD_SIZE-16){1'b0}}, load_half}
                                     : {{(WORD_SIZE-16){load_half[15]}}, load_half};
      default: load_ext = mem_read_data;
    endcase
  end

  // Read-modify-write merge: only the addressed lane takes new store data.
  always_comb begin
    merged = mem_read_data;
    case (size_q)
      2'b00:   merged[{offset_q, 3'b000} +: 8]     = wdata_q[7:0];
      2'b01:   merged[{offset_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign mem_read_address  = req_address[ADDRESS_SIZE+1:2];
  assign mem_write_address = waddr_q;
  assign mem_write_data    = merged;
  assign resp_data         = resp_data_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - scoreboard bench for memory_access_unit with a RAM model
module tb_memory_access_unit;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW+1:0] req_address = '0;
  logic [DW-1:0] req_write_data = '0;
  logic          resp_valid;
  logic          resp_error;
  logic [DW-1:0] resp_data;
  logic          mem_read_enable;
  logic          mem_write_enable;
  logic [AW-1:0] mem_read_address;
  logic [AW-1:0] mem_write_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;

  memory_access_unit #(.ADDRESS_SIZE(AW), .WORD_SIZE(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
    .req_write_data(req_write_data),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_data(resp_data),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ram [0:(1<<AW)-1];
  logic [31:0] rd_q = '0;
  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_write_address] <= mem_write_data;
    if (mem_read_enable) rd_q <= ram[mem_read_address];
  end
  assign mem_read_data = rd_q;

  bit [31:0] ref_mem [0:(1<<AW)-1];

  typedef struct { bit err; bit [31:0] data; int cyc; } resp_t;
  typedef struct { bit [AW-1:0] addr; bit [31:0] data; int cyc; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  int checks = 0;
  int errors = 0;
  int last_accept = 0;
  bit [31:0] last_resp_data = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input bit wr, input bit [1:0] sz, input bit uns,
                       input bit [AW+1:0] a, input bit [31:0] wd, input bit track = 1);
    bit err;
    int n, t, waited;
    bit [AW-1:0] idx;
    bit [31:0] word, val;
    longint sv;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    @(negedge clk);
    req_write = wr; req_size = sz; req_unsigned = uns;
    req_address = a; req_write_data = wd; req_valid = 1'b1;
    waited = 0;
    #1;
    while (!req_ready) begin
      if (waited > 20) begin
        chk("accept_timeout", 0, 1);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk); #1;
      waited++;
    end
    t = cyc;
    chk("read_enable_on_accept", mem_read_enable, !err);
    if (!err) chk("read_address", mem_read_address, a[AW+1:2]);
    last_accept = t;
    if (track) begin
      n = 1 << sz;
      idx = a[AW+1:2];
      word = ref_mem[idx];
      if (err) begin
        rq.push_back('{1'b1, 32'h0, t + 1});
        last_resp_data = 0;
      end else if (wr) begin
        for (int i = 0; i < n; i++) word[8*(a[1:0]+i) +: 8] = wd[8*i +: 8];
        ref_mem[idx] = word;
        wq.push_back('{idx, word, t + 1});
        rq.push_back('{1'b0, 32'h0, t + 2});
        last_resp_data = 0;
      end else begin
        val = 0;
        for (int i = 0; i < n; i++) val[8*i +: 8] = word[8*(a[1:0]+i) +: 8];
        sv = longint'(val);
        if (!uns && n < 4 && val[8*n-1]) sv = sv - (longint'(1) << (8*n));
        rq.push_back('{1'b0, sv[31:0], t + 2});
        last_resp_data = sv[31:0];
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (rq.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        resp_t e;
        e = rq.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_error", resp_error, e.err);
        chk("resp_data", resp_data, e.data);
      end
    end
  end

  // Write monitor: every RAM write must match the oldest expected store.
  always @(negedge clk) begin
    if (mem_write_enable) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("write_cycle", cyc, w.cyc);
        chk("write_address", mem_write_address, w.addr);
        chk("write_data", mem_write_data, w.data);
      end
    end
  end

  initial begin
    int t1, t2, waited;
    bit [AW+1:0] a;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end

    repeat (3) @(negedge clk);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_error", resp_error, 0);
    chk("reset_resp_data", resp_data, 0);
    chk("reset_mem_write_enable", mem_write_enable, 0);
    reset = 1'b0;
    #1;
    chk("reset_req_ready", req_ready, 1);

    // Store then load, held back-to-back: accepts three cycles apart.
    issue(1, 2'd2, 0, 12'h010, 32'hDEADBEEF);
    t1 = last_accept;
    chk("ready_low_in_access", req_ready, 0);
    issue(0, 2'd2, 0, 12'h010, 32'h0);
    t2 = last_accept;
    chk("accept_spacing_aligned", t2 - t1, 3);
    issue(1, 2'd0, 0, 12'h011, 32'hFFFFFF55);
    issue(0, 2'd2, 0, 12'h010, 32'h0);
    idle(2);

    // Lane selection and extension.
    issue(1, 2'd2, 0, 12'h020, 32'h8000F0F0);
    issue(0, 2'd0, 0, 12'h021, 32'h0);
    issue(0, 2'd0, 1, 12'h021, 32'h0);
    issue(0, 2'd1, 0, 12'h022, 32'h0);
    issue(0, 2'd1, 1, 12'h022, 32'h0);
    idle(1);

    // Misaligned and illegal requests.
    issue(0, 2'd2, 0, 12'h013, 32'h0);
    t1 = last_accept;
    issue(1, 2'd1, 0, 12'h011, 32'h12345678);
    t2 = last_accept;
    chk("accept_spacing_error", t2 - t1, 2);
    issue(0, 2'd3, 0, 12'h010, 32'h0);
    issue(0, 2'd2, 0, 12'h010, 32'h0);
    idle(2);

    // Reset while a byte store is in ACCESS: no write, no response.
    issue(1, 2'd0, 0, 12'h011, 32'h000000AA, 0);
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("reset_access_write_enable", mem_write_enable, 0);
    chk("reset_access_resp_valid", resp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_access_idle", req_ready, 1);
    issue(0, 2'd2, 0, 12'h010, 32'h0);
    idle(1);

    // Address boundaries.
    issue(1, 2'd2, 0, 12'h000, $urandom);
    issue(1, 2'd2, 0, 12'hFFC, $urandom);
    issue(1, 2'd0, 0, 12'hFFF, 32'h00000081);
    issue(0, 2'd2, 0, 12'h000, 32'h0);
    issue(0, 2'd2, 0, 12'hFFC, 32'h0);
    issue(0, 2'd0, 0, 12'hFFF, 32'h0);
    idle(1);

    // Randomised traffic over a small window plus the top word.
    for (int k = 0; k < 150; k++) begin
      a[AW+1:2] = ($urandom_range(0, 9) == 9) ? {AW{1'b1}} : AW'($urandom_range(0, 7));
      a[1:0] = 2'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    idle(1);

    waited = 0;
    while ((rq.size() != 0 || wq.size() != 0) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_resp", rq.size(), 0);
    chk("drain_write", wq.size(), 0);
    repeat (3) @(negedge clk);
    chk("resp_data_held", resp_data, last_resp_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
